// File: rtl/seq_right_rotator.sv
// Multi-cycle right rotator / logical right shifter: one bit position per clock,
// valid/ready on both sides, a single operation in flight.
module seq_right_rotator #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_out_data;

  logic [WIDTH-1:0] w_step;
  logic             w_accept;

  // One bit of right movement; the vacated MSB takes the old LSB only when rotating.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] d, input logic rot);
    return {rot & d[0], d[WIDTH-1:1]};
  endfunction

  assign w_step   = shift_one(r_work, r_mode);
  assign w_accept = (r_state == S_IDLE) && in_valid && r_in_ready;

  // Control path: state, counter, handshake flags and the published result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_cnt      <= in_amt;
            r_mode     <= in_rot;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (in_amt == '0) begin
              r_out_data  <= in_data;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_out_data  <= w_step;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Re-arm in_ready at the handshake edge so the very next cycle can accept.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Working register: loaded on accept, stepped while shifting; needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_work <= in_data;
    end else if (r_state == S_SHIFT) begin
      r_work <= w_step;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_right_rotator.sv
// Directed and randomized checks of seq_right_rotator against hand-computed
// values and an arithmetic reference model.
module tb_seq_right_rotator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       in_rot;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  seq_right_rotator #(.WIDTH(8), .AMT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_rot   (in_rot),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic formulation of a right rotate / logical shift.
  function automatic logic [7:0] ref_rr(input logic [7:0] d, input int a, input logic rot);
    logic [15:0] w;
    w = {d, d} >> a;
    return rot ? w[7:0] : (d >> a);
  endfunction

  // Presents a request at a negedge, lets it be accepted, then scrambles the inputs.
  task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic r, input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_amt   = a;
    in_rot   = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_amt   = ~a;
    in_rot   = ~r;
  endtask

  // Called one negedge after the accept edge; counts edges until out_valid.
  task automatic wait_result(input int a, input logic [7:0] exp, input string tag);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, a + 1);
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_rot    = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // T1 rotate F0 by 4
    issue(8'hF0, 3'd4, 1'b1, "t1");
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_in_ready_shift", {31'd0, in_ready}, 32'd0);
    chk("t1_hold_data", {24'd0, out_data}, 32'd0);
    wait_result(4, 8'h0F, "t1");
    chk("t1_in_ready_done", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t1_busy_drop", {31'd0, busy}, 32'd0);
    chk("t1_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("t1_out_held", {24'd0, out_data}, 32'h0F);

    // T2 wrap cases
    issue(8'h81, 3'd1, 1'b1, "t2a");
    wait_result(1, 8'hC0, "t2a");
    @(negedge clk);
    issue(8'h01, 3'd7, 1'b1, "t2b");
    wait_result(7, 8'h02, "t2b");
    @(negedge clk);

    // T3 logical
    issue(8'hF0, 3'd3, 1'b0, "t3a");
    wait_result(3, 8'h1E, "t3a");
    @(negedge clk);
    issue(8'hFF, 3'd7, 1'b0, "t3b");
    wait_result(7, 8'h01, "t3b");
    @(negedge clk);

    // T4 zero amount
    issue(8'hA5, 3'd0, 1'b1, "t4");
    wait_result(0, 8'hA5, "t4");
    @(negedge clk);
    chk("t4_valid_drop", {31'd0, out_valid}, 32'd0);

    // T5 backpressure with a competing request held during the stall
    out_ready = 1'b0;
    issue(8'hF0, 3'd4, 1'b1, "t5");
    wait_result(4, 8'h0F, "t5");
    in_data  = 8'hC3;
    in_amt   = 3'd2;
    in_rot   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_stall_data", {24'd0, out_data}, 32'h0F);
      chk("t5_stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_hs_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_second_busy", {31'd0, busy}, 32'd1);
    wait_result(2, 8'h30, "t5b");
    @(negedge clk);

    // T6 reset in the middle of a shift
    issue(8'h5A, 3'd6, 1'b1, "t6");
    @(negedge clk);
    @(negedge clk);
    chk("t6_mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_out_data", {24'd0, out_data}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random sweep against the reference model
    for (int k = 0; k < 60; k++) begin
      logic [7:0] d;
      logic [2:0] a;
      logic       r;
      d = 8'($urandom_range(0, 255));
      a = 3'($urandom_range(0, 7));
      r = 1'($urandom_range(0, 1));
      issue(d, a, r, "rnd");
      wait_result(int'(a), ref_rr(d, int'(a), r), "rnd");
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
